nearest_value_tracker: RTL
==========================

Name: nearest_value_tracker

Overview:
Streaming nearest-value search stage that sits directly upstream of LessDistance-style pairwise selection in the datapath. It takes a reference and a burst of up to 2^CNT_W-1 candidates over a valid/ready handshake. It tracks the candidate closest to the reference using absolute difference. It reports the winning value, its distance and its index with a one-cycle done pulse.

Parameters:
WIDTH, 8, bit width of reference, candidates and distance
CNT_W, 4, width of candidate count and index (max burst 15 at default)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a search; sampled only in IDLE
reff  input  WIDTH  reference value, latched on accepted start
count  input  CNT_W  number of candidates in burst, latched on accepted start
in_valid  input  1  candidate present on in_data
in_data  input  WIDTH  candidate value
in_ready  output  1  block accepts a candidate this cycle
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, results valid
best  output  WIDTH  closest candidate value
best_dist  output  WIDTH  |best - reff|
best_idx  output  CNT_W  position of best in burst (0-based)

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n). All state updates occur on the rising edge of clk.
- On reset assertion, the block goes to IDLE immediately. in_ready, busy and done go to 0. best, best_dist and best_idx go to 0. The beat counter goes to 0. Reset mid-burst abandons the search with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - If start=1 and count!=0: latch reff and count, clear the beat counter, go to RUN.
  - If start=1 and count==0: go to DONE with best=0, best_dist=all ones, best_idx=0.
- RUN:
  - in_ready=1, busy=1. A beat is accepted when in_valid && in_ready.
  - dist = (in_data >= reff_latched) ? in_data - reff_latched : reff_latched - in_data. This is an unsigned WIDTH-bit value with no wrap; the maximum is 2^WIDTH-1.
  - For the first beat (index 0), best, best_dist and best_idx are loaded unconditionally.
  - For later beats, update only when dist < best_dist (strict less). Ties keep the earlier, lower-index candidate.
  - The beat counter increments per accepted beat. When the accepted beat is index count-1, go to DONE.
  - Cycles with in_valid=0 are stalls: no state change.
- DONE:
  - Lasts exactly one cycle. done=1, busy=1, in_ready=0. Next state is IDLE.
- Latency: done is asserted in the cycle immediately after the last accepted beat's clock edge.
- Results persist until the next accepted start or reset. They are not cleared on leaving DONE.
- start while in RUN or DONE is ignored. Changes to reff/count after the start is accepted have no effect.
- in_data arriving while in_ready=0 is ignored and not consumed.

Test Plan:
- Basic search: reset, then start with reff=100, count=3; send 90, 107, 95 back-to-back -> done on the cycle after the 3rd beat; best=95, best_dist=5, best_idx=2.
- Tie rule: reff=50, count=2; send 40, 60 -> best=40, best_dist=10, best_idx=0.
- Range extremes: reff=0, count=2; send 255, 1 -> best=1, dist=1, idx=1. Then reff=255, count=1; send 0 -> best=0, dist=255, idx=0.
- Stalls and start-ignore: reff=8, count=4; in_valid toggled 1,0,0,1,1,0,1 with data 20, 3, 9, 12 on valid beats; start pulsed mid-burst -> only 4 beats consumed, start ignored; best=9, dist=1, idx=2; done exactly once.
- count=0: start with count=0 -> done one cycle later; best=0, best_dist=8'hFF, best_idx=0; in_ready never high.
- Reset mid-run: start with count=5, accept 2 beats, assert rst_n=0 asynchronously between edges -> outputs zero immediately, no done. After release, a new start with reff=10, count=1 and data 12 -> best=12, dist=2.

Source files
------------

// File: rtl/nearest_value_tracker_if.sv
// nearest_value_tracker_if: start/burst handshake and result bus of the nearest-value search
interface nearest_value_tracker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] reff;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] best;
  logic [WIDTH-1:0] best_dist;
  logic [CNT_W-1:0] best_idx;
  modport master (
    output start, reff, count, in_valid, in_data,
    input  in_ready, busy, done, best, best_dist, best_idx
  );
  modport slave (
    input  start, reff, count, in_valid, in_data,
    output in_ready, busy, done, best, best_dist, best_idx
  );
endinterface

// File: rtl/nearest_value_tracker.sv
// nearest_value_tracker: streams a burst of candidates and keeps the one closest to a reference
module nearest_value_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nearest_value_tracker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_reff, r_best, r_dist, w_dist;
  logic [CNT_W-1:0] r_count, r_cnt, r_idx;
  logic             w_acc, w_last;
  assign w_dist = (bus.in_data >= r_reff) ? bus.in_data - r_reff : r_reff - bus.in_data;
  assign w_acc  = (r_state == RUN) && bus.in_valid;
  assign w_last = w_acc && (r_cnt == r_count - CNT_W'(1));
  assign bus.best      = r_best;
  assign bus.best_dist = r_dist;
  assign bus.best_idx  = r_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next       = r_state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = (bus.count != '0) ? RUN : DONE;
      RUN: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // the first beat seeds the result; later beats replace it only when strictly closer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_reff  <= '0;
      r_count <= '0;
      r_cnt   <= '0;
      r_best  <= '0;
      r_dist  <= '0;
      r_idx   <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_cnt <= '0;
      if (bus.count != '0) begin
        r_reff  <= bus.reff;
        r_count <= bus.count;
      end else begin
        r_best <= '0;
        r_dist <= '1;
        r_idx  <= '0;
      end
    end else if (w_acc) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == '0 || w_dist < r_dist) begin
        r_best <= bus.in_data;
        r_dist <= w_dist;
        r_idx  <= r_cnt;
      end
    end
endmodule
